chimera_clu_pwr_seq: RTL and testbench

Per-cluster power sequencer for the Chimera cluster domain. It replaces the static per-cluster clock-gate and isolation wiring with one handshaked state machine per cluster, parametrised in cluster count and cycle budgets. For each cluster it orders clock enable, cluster reset and AXI isolation, so a cluster can be brought up or down from a single level request driven by the top-level register file.

---
 rtl/chimera_pkg.sv | 26 ++
 rtl/chimera_clu_pwr_fsm.sv | 164 ++++++++++++++++
 rtl/chimera_clu_pwr_seq.sv | 59 +++++
 tb/tb_chimera_clu_pwr_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/chimera_pkg.sv
// rtl/chimera_pkg.sv - shared types and defaults for the Chimera cluster power sequencer
package chimera_pkg;

  typedef enum logic [2:0] {
    CluOff   = 3'd0,
    CluClkOn = 3'd1,
    CluDeiso = 3'd2,
    CluOn    = 3'd3,
    CluIso   = 3'd4,
    CluFlush = 3'd5
  } clu_pwr_state_e;

  localparam int CluPwrRstCycles     = 8;
  localparam int CluPwrFlushCycles   = 4;
  localparam int CluPwrTimeoutCycles = 1024;

  // One counter serves every timed state, so it must hold the largest budget.
  function automatic int clu_pwr_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// rtl/chimera_clu_pwr_fsm.sv - single-cluster power FSM with shared down-counter
// Isolation-ack timeout compiled in with CHIMERA_CLU_PWR_TIMEOUT_EN.
module chimera_clu_pwr_fsm
  import chimera_pkg::*;
#(
  parameter int RstCycles     = CluPwrRstCycles,
  parameter int FlushCycles   = CluPwrFlushCycles,
  parameter int TimeoutCycles = CluPwrTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic on_req_i,
  input  logic iso_ack_i,
  input  logic err_clr_i,
  output logic iso_o,
  output logic clk_en_o,
  output logic clu_rst_no,
  output logic active_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam int CntW = clu_pwr_cnt_width(RstCycles, FlushCycles, TimeoutCycles);
  localparam logic [CntW-1:0] RstLoad   = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] FlushLoad = CntW'(FlushCycles - 1);
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
  localparam logic [CntW-1:0] WaitLoad  = CntW'(TimeoutCycles - 1);
`else
  localparam logic [CntW-1:0] WaitLoad  = '0;
`endif

  clu_pwr_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d, err_set;
  logic            iso_q, iso_d, clk_en_q, clk_en_d, rst_n_q, rst_n_d;
  logic            active_q, active_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      CluOff: begin
        if (on_req_i) begin
          state_d = CluClkOn;
          cnt_d   = RstLoad;
        end
      end
      CluClkOn: begin
        if (cnt_q == '0) begin
          state_d = CluDeiso;
          cnt_d   = WaitLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      CluDeiso: begin
        if (!iso_ack_i) begin
          state_d = CluOn;
          cnt_d   = '0;
        end
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
        else if (cnt_q == '0) begin
          // Domain never released isolation: back out through the power-down path.
          state_d = CluIso;
          cnt_d   = WaitLoad;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
`endif
      end
      CluOn: begin
        if (!on_req_i) begin
          state_d = CluIso;
          cnt_d   = WaitLoad;
        end
      end
      CluIso: begin
        if (iso_ack_i) begin
          state_d = CluFlush;
          cnt_d   = FlushLoad;
        end
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = CluFlush;
          cnt_d   = FlushLoad;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
`endif
      end
      CluFlush: begin
        if (cnt_q == '0) begin
          state_d = CluOff;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = CluOff;
        cnt_d   = '0;
      end
    endcase

`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
`else
    err_d = 1'b0;
`endif

    // Outputs decode from the next state so the registered copies track state_q exactly.
    iso_d    = (state_d == CluOff) || (state_d == CluClkOn) ||
               (state_d == CluIso) || (state_d == CluFlush);
    clk_en_d = (state_d != CluOff);
    rst_n_d  = (state_d == CluDeiso) || (state_d == CluOn) || (state_d == CluIso);
    active_d = (state_d == CluOn);
    busy_d   = (state_d != CluOff) && (state_d != CluOn);
    done_d   = ((state_d == CluOn)  && (state_q == CluDeiso)) ||
               ((state_d == CluOff) && (state_q == CluFlush));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CluOff;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      iso_q    <= 1'b1;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      iso_q    <= iso_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifndef CHIMERA_CLU_PWR_TIMEOUT_EN
  logic unused_err_inputs;
  assign unused_err_inputs = err_clr_i ^ err_set;
`endif

  assign iso_o      = iso_q;
  assign clk_en_o   = clk_en_q;
  assign clu_rst_no = rst_n_q;
  assign active_o   = active_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// rtl/chimera_clu_pwr_seq.sv - per-cluster power sequencer, one FSM per cluster
// Optional isolation-ack timeout: CHIMERA_CLU_PWR_TIMEOUT_EN.
module chimera_clu_pwr_seq
  import chimera_pkg::*;
#(
  parameter int NumClusters   = 5,
  parameter int RstCycles     = CluPwrRstCycles,
  parameter int FlushCycles   = CluPwrFlushCycles,
  parameter int TimeoutCycles = CluPwrTimeoutCycles
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] on_req_i,
  input  logic [NumClusters-1:0] iso_ack_i,
  input  logic [NumClusters-1:0] err_clr_i,
  output logic [NumClusters-1:0] iso_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] active_o,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] done_o,
  output logic [NumClusters-1:0] err_o
);

  if (NumClusters < 1) begin : g_bad_num
    $error("NumClusters must be >= 1");
  end
  if (RstCycles < 1) begin : g_bad_rst
    $error("RstCycles must be >= 1");
  end
  if (FlushCycles < 1) begin : g_bad_flush
    $error("FlushCycles must be >= 1");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be >= 1");
  end

  for (genvar i = 0; i < NumClusters; i++) begin : g_clu
    chimera_clu_pwr_fsm #(
      .RstCycles    (RstCycles),
      .FlushCycles  (FlushCycles),
      .TimeoutCycles(TimeoutCycles)
    ) u_fsm (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .on_req_i  (on_req_i[i]),
      .iso_ack_i (iso_ack_i[i]),
      .err_clr_i (err_clr_i[i]),
      .iso_o     (iso_o[i]),
      .clk_en_o  (clk_en_o[i]),
      .clu_rst_no(clu_rst_no[i]),
      .active_o  (active_o[i]),
      .busy_o    (busy_o[i]),
      .done_o    (done_o[i]),
      .err_o     (err_o[i])
    );
  end

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// tb/tb_chimera_clu_pwr_seq.sv - randomized self-checking bench with a phase/age reference model
module tb_chimera_clu_pwr_seq;

  localparam int N = 5;
  localparam int R = 8;
  localparam int F = 4;

  localparam int P_OFF = 0, P_CLK = 1, P_DEISO = 2, P_ON = 3, P_ISO = 4, P_FLUSH = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] on_req, iso_ack, err_clr;
  logic [N-1:0] iso, clk_en, clu_rst_n, active, busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  int ph  [N];
  int age [N];
  bit mdone [N];

  always #5 clk = ~clk;

  chimera_clu_pwr_seq #(
    .NumClusters  (N),
    .RstCycles    (R),
    .FlushCycles  (F),
    .TimeoutCycles(1024)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .on_req_i  (on_req),
    .iso_ack_i (iso_ack),
    .err_clr_i (err_clr),
    .iso_o     (iso),
    .clk_en_o  (clk_en),
    .clu_rst_no(clu_rst_n),
    .active_o  (active),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Phase advances by the sequencing rules: timed phases end once they have lasted their budget.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int nx;
      if (rst) begin
        ph[i] = P_OFF; age[i] = 0; mdone[i] = 1'b0;
        continue;
      end
      nx = ph[i];
      case (ph[i])
        P_OFF:   if (on_req[i])   nx = P_CLK;
        P_CLK:   if (age[i] == R) nx = P_DEISO;
        P_DEISO: if (!iso_ack[i]) nx = P_ON;
        P_ON:    if (!on_req[i])  nx = P_ISO;
        P_ISO:   if (iso_ack[i])  nx = P_FLUSH;
        default: if (age[i] == F) nx = P_OFF;
      endcase
      mdone[i] = (nx != ph[i]) && (nx == P_ON || nx == P_OFF);
      age[i]   = (nx != ph[i]) ? 1 : age[i] + 1;
      ph[i]    = nx;
    end
  endtask

  function automatic logic [N-1:0] exp_vec(input int field);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      case (field)
        0: v[i] = (ph[i] == P_OFF) || (ph[i] == P_CLK) || (ph[i] == P_ISO) || (ph[i] == P_FLUSH);
        1: v[i] = (ph[i] != P_OFF);
        2: v[i] = (ph[i] == P_DEISO) || (ph[i] == P_ON) || (ph[i] == P_ISO);
        3: v[i] = (ph[i] == P_ON);
        4: v[i] = (ph[i] != P_OFF) && (ph[i] != P_ON);
        5: v[i] = mdone[i];
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("iso",    iso,       exp_vec(0));
    check_eq("clk_en", clk_en,    exp_vec(1));
    check_eq("rst_n",  clu_rst_n, exp_vec(2));
    check_eq("active", active,    exp_vec(3));
    check_eq("busy",   busy,      exp_vec(4));
    check_eq("done",   done,      exp_vec(5));
    check_eq("err",    err,       exp_vec(6));
  endtask

  initial begin
    rst = 1'b1; on_req = '0; iso_ack = '1; err_clr = '0;
    for (int i = 0; i < N; i++) begin ph[i] = P_OFF; age[i] = 0; mdone[i] = 1'b0; end
    @(negedge clk);
    step();
    check_eq("rst_iso",    iso,       {N{1'b1}});
    check_eq("rst_clk_en", clk_en,    '0);
    check_eq("rst_rst_n",  clu_rst_n, '0);
    check_eq("rst_done",   done,      '0);
    rst = 1'b0;
    step();

    // Directed power-up of cluster 0: ack drops 3 cycles into DEISO.
    on_req[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      check_eq($sformatf("up_clk_en_k%0d", k), clk_en[0],    (k >= 1));
      check_eq($sformatf("up_rst_n_k%0d", k),  clu_rst_n[0], (k >= 9));
      check_eq($sformatf("up_active_k%0d", k), active[0],    (k >= 12));
      check_eq($sformatf("up_done_k%0d", k),   done[0],      (k == 12));
      if (k == 11) iso_ack[0] = 1'b0;
    end

    // Directed power-down of cluster 0 with immediate ack.
    on_req[0] = 1'b0; iso_ack[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq($sformatf("dn_iso_k%0d", k),    iso[0],       1'b1);
      check_eq($sformatf("dn_rst_n_k%0d", k),  clu_rst_n[0], (k < 2));
      check_eq($sformatf("dn_clk_en_k%0d", k), clk_en[0],    (k < 6));
      check_eq($sformatf("dn_done_k%0d", k),   done[0],      (k == 6));
    end

    // Request withdrawn during CLK_ON: ON must still be reached before ISO.
    on_req[1] = 1'b1; iso_ack[1] = 1'b0;
    step();
    on_req[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      iso_ack[1] = (ph[1] == P_ISO) || (ph[1] == P_FLUSH);
    end

    // All clusters requested together, acks released at staggered times.
    iso_ack = '1; on_req = '1;
    for (int k = 0; k < 30; k++) begin
      step();
      for (int i = 0; i < N; i++) if (k >= 10 + 2 * i) iso_ack[i] = 1'b0;
    end

    // Reset mid-sequence while some clusters are on and others transient.
    on_req = '0; iso_ack = '0;
    on_req[2] = 1'b1;
    step();
    on_req = '1;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    check_eq("midrst_iso",    iso,    {N{1'b1}});
    check_eq("midrst_active", active, '0);
    check_eq("midrst_busy",   busy,   '0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 24) == 0) on_req[i] = ~on_req[i];
        if ($urandom_range(0, 3) == 0) iso_ack[i] = $urandom_range(0, 1) == 1;
      end
      err_clr = N'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
